// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller that sequences the 16-bit ALU and the
// register file for one decoded instruction at a time, and issues PC-relative
// load requests to fetch for branch-class instructions.
//
// state  | meaning
// -------+--------------------------------------------------------------------
// IDLE   | ready for an instruction; reserved-class instructions dropped here
// READ   | rd/rs read from the register file, captured into the ALU inputs
// EXEC   | ALU evaluates the captured operands; result registered at cycle end
// WB     | registered ALU result written back to rd (suppressed for CMP)
// BRANCH | ALU evaluates the condition code; pc_load follows the ALU decision
module alu_sequencer #(
  parameter int         DATA_W  = 16,
  parameter int         RADDR_W = 3,
  parameter int         BOFF_W  = 10,
  // Must track the OP_CMP encoding of the ALU (cpu_data.v).
  parameter logic [3:0] OP_CMP  = 4'h7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [15:0]        instr,
  output logic [RADDR_W-1:0] rf_raddr_a,
  output logic [RADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic [DATA_W-1:0]  alu_value1,
  output logic [DATA_W-1:0]  alu_value2,
  output logic [3:0]         alu_operator,
  output logic               alu_single,
  input  logic [DATA_W-1:0]  alu_bus_out,
  input  logic               alu_check_branch,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               pc_load,
  output logic [DATA_W-1:0]  pc_offset,
  output logic               busy,
  output logic               illegal
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_BRANCH = 3'd4;

  localparam logic [1:0] CLS_DUAL   = 2'b00;
  localparam logic [1:0] CLS_SINGLE = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;

  logic [2:0]         state_q, state_d;
  logic [15:0]        instr_q, instr_d;
  logic [DATA_W-1:0]  alu_value1_q, alu_value1_d;
  logic [DATA_W-1:0]  alu_value2_q, alu_value2_d;
  logic [3:0]         alu_operator_q, alu_operator_d;
  logic               alu_single_q, alu_single_d;
  logic               illegal_q, illegal_d;

  logic [1:0]         cls_in;
  logic [1:0]         cls_q;
  logic [3:0]         opr_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RADDR_W-1:0] rs_q;
  logic [DATA_W-1:0]  boff_sext;

  assign cls_in    = instr[15:14];
  assign cls_q     = instr_q[15:14];
  assign opr_q     = instr_q[13:10];
  assign rd_q      = instr_q[7 +: RADDR_W];
  assign rs_q      = instr_q[4 +: RADDR_W];
  assign boff_sext = {{(DATA_W-BOFF_W){instr_q[BOFF_W-1]}}, instr_q[BOFF_W-1:0]};

  // Next-state, instruction latch and ALU input registers.
  // The ALU inputs are registers so they hold their last value outside
  // EXEC/BRANCH; they are loaded on the edge that enters EXEC or BRANCH so the
  // ALU sees stable operands and operator for the whole cycle.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    alu_value1_d   = alu_value1_q;
    alu_value2_d   = alu_value2_q;
    alu_operator_d = alu_operator_q;
    alu_single_d   = alu_single_q;
    illegal_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          case (cls_in)
            CLS_DUAL, CLS_SINGLE: begin
              instr_d = instr;
              state_d = S_READ;
            end
            CLS_BRANCH: begin
              instr_d        = instr;
              alu_operator_d = instr[13:10];
              alu_single_d   = 1'b0;
              state_d        = S_BRANCH;
            end
            default: begin
              // Reserved class: dropped without touching any other state.
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_READ: begin
        alu_value1_d   = rf_rdata_a;
        alu_value2_d   = (cls_q == CLS_SINGLE) ? '0 : rf_rdata_b;
        alu_operator_d = opr_q;
        alu_single_d   = (cls_q == CLS_SINGLE);
        state_d        = S_EXEC;
      end
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      S_BRANCH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      instr_q        <= '0;
      alu_value1_q   <= '0;
      alu_value2_q   <= '0;
      alu_operator_q <= '0;
      alu_single_q   <= 1'b0;
      illegal_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      alu_value1_q   <= alu_value1_d;
      alu_value2_q   <= alu_value2_d;
      alu_operator_q <= alu_operator_d;
      alu_single_q   <= alu_single_d;
      illegal_q      <= illegal_d;
    end
  end

  // Per-state register-file and fetch strobes.
  // rf_we and pc_load are qualified with rst_n: a reset sampled on the same
  // edge as a WB or BRANCH cycle must not let the write or PC load escape.
  always_comb begin
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pc_load    = 1'b0;
    pc_offset  = '0;
    case (state_q)
      S_READ: begin
        rf_raddr_a = rd_q;
        rf_raddr_b = rs_q;
      end
      S_WB: begin
        rf_we    = rst_n && (opr_q != OP_CMP);
        rf_waddr = rd_q;
        rf_wdata = alu_bus_out;
      end
      S_BRANCH: begin
        pc_load   = rst_n && alu_check_branch;
        pc_offset = boff_sext;
      end
      default: ;
    endcase
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign illegal      = illegal_q;
  assign alu_value1   = alu_value1_q;
  assign alu_value2   = alu_value2_q;
  assign alu_operator = alu_operator_q;
  assign alu_single   = alu_single_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural register file and ALU around the
// DUT, directed instructions, and a scoreboard of expected write / branch /
// illegal events with the cycle they must appear in.
`timescale 1ns/1ps
module tb_alu_sequencer;

  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_PC  = 2'd2;
  localparam logic [1:0] K_ILL = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_CMP  = 4'h7;
  localparam logic [3:0] OP_LSL  = 4'h0;
  localparam logic [3:0] OP_LSR  = 4'h1;
  localparam logic [3:0] OP_RJMP = 4'h0;
  localparam logic [3:0] OP_BRNC = 4'h3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  rf_raddr_a, rf_raddr_b;
  logic [15:0] rf_rdata_a, rf_rdata_b;
  logic [15:0] alu_value1, alu_value2;
  logic [3:0]  alu_operator;
  logic        alu_single;
  logic [15:0] alu_bus_out = 16'h0000;
  logic        alu_check_branch;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pc_load;
  logic [15:0] pc_offset;
  logic        busy;
  logic        illegal;

  logic [15:0] rf [8];
  logic [15:0] init_val [8] = '{16'h1234, 16'h0003, 16'h0005, 16'h8001,
                                16'h0010, 16'h0020, 16'h0100, 16'h0001};
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;
  logic        br_take;
  logic [31:0] cyc = 32'd0;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_operator(alu_operator), .alu_single(alu_single),
    .alu_bus_out(alu_bus_out), .alu_check_branch(alu_check_branch),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_load(pc_load), .pc_offset(pc_offset),
    .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // Register file: combinational reads, writes on posedge.
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  // ALU: registered result, combinational branch decision from the bench.
  assign alu_check_branch = br_take;
  always @(posedge clk) begin
    if (alu_single) begin
      if (alu_operator == OP_LSL)      alu_bus_out <= alu_value1 << 1;
      else if (alu_operator == OP_LSR) alu_bus_out <= alu_value1 >> 1;
      else                             alu_bus_out <= ~alu_value1;
    end else begin
      if (alu_operator == OP_ADD)                                alu_bus_out <= alu_value1 + alu_value2;
      else if (alu_operator == OP_SUB || alu_operator == OP_CMP) alu_bus_out <= alu_value1 - alu_value2;
      else                                                       alu_bus_out <= alu_value1 & alu_value2;
    end
  end

  // Monitor: every write / pc_load / illegal strobe is matched against the queue.
  always @(negedge clk) begin
    ev_t obs;
    ev_t e;
    if (rf_we || pc_load || illegal) begin
      obs = '0;
      obs.cyc = cyc;
      if (rf_we) begin
        obs.kind = K_WR; obs.addr = rf_waddr; obs.data = rf_wdata;
      end else if (pc_load) begin
        obs.kind = K_PC; obs.data = pc_offset;
      end else begin
        obs.kind = K_ILL;
      end
      n_cmp++;
      if (32'(rf_we) + 32'(pc_load) + 32'(illegal) > 32'd1) begin
        n_err++;
        $display("FAIL strobe_exclusive: got we=%0b pc_load=%0b illegal=%0b at cyc %0d, need at most one",
                 rf_we, pc_load, illegal, cyc);
      end else if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_unexpected: got kind=%0d addr=%0d data=0x%h cyc=%0d, expected no event",
                 obs.kind, obs.addr, obs.data, obs.cyc);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_err++;
          $display("FAIL scoreboard_event: got kind=%0d addr=%0d data=0x%h cyc=%0d, expected kind=%0d addr=%0d data=0x%h cyc=%0d",
                   obs.kind, obs.addr, obs.data, obs.cyc, e.kind, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic logic [15:0] mk_alu(input logic [1:0] cls, input logic [3:0] op,
                                         input logic [2:0] rd, input logic [2:0] rs);
    return {cls, op, rd, rs, 4'b0000};
  endfunction

  function automatic logic [15:0] mk_br(input logic [3:0] op, input logic [9:0] off);
    return {2'b10, op, off};
  endfunction

  // Present an instruction when the DUT is ready; acc = cycle number right
  // after the accepting edge (the READ/BRANCH/illegal cycle).
  task automatic issue(input logic [15:0] ins, output logic [31:0] acc);
    int w;
    w = 0;
    while (!instr_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!instr_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: got instr_ready=0 for 50 cycles, expected 1");
      acc = cyc;
    end else begin
      instr_valid = 1'b1;
      instr = ins;
      @(posedge clk);
      #1;
      acc = cyc;
      instr_valid = 1'b0;
      instr = 16'hFFFF;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] a2;
    instr_valid = 1'b0;
    instr = 16'h0000;
    br_take = 1'b0;
    pl_en = 1'b0;
    pl_addr = 3'd0;
    pl_data = 16'h0000;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_raddr", 32'({rf_raddr_a, rf_raddr_b, rf_waddr}), 0);
    chk("rst_wdata", 32'(rf_wdata), 0);
    chk("rst_pc_offset", 32'(pc_offset), 0);
    chk("rst_alu_vals", {alu_value1, alu_value2}, 0);
    chk("rst_alu_op", 32'({alu_operator, alu_single}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pl_en = 1'b1;
      pl_addr = 3'(i);
      pl_data = init_val[i];
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // ADD r1,r2: 3 + 5 = 8 written to r1 in WB
    issue(mk_alu(2'b00, OP_ADD, 3'd1, 3'd2), a);
    exp_q.push_back(ev_t'{K_WR, 3'd1, 16'h0008, a + 32'd2});
    @(negedge clk);
    chk("add_ready_read", 32'(instr_ready), 0);
    chk("add_raddr_a", 32'(rf_raddr_a), 1);
    chk("add_raddr_b", 32'(rf_raddr_b), 2);
    @(negedge clk);
    chk("add_ready_exec", 32'(instr_ready), 0);
    chk("add_exec_v1", 32'(alu_value1), 'h0003);
    chk("add_exec_v2", 32'(alu_value2), 'h0005);
    chk("add_exec_op", 32'({alu_operator, alu_single}), 32'({OP_ADD, 1'b0}));
    @(negedge clk);
    chk("add_ready_wb", 32'(instr_ready), 0);
    @(negedge clk);
    chk("add_ready_idle", 32'(instr_ready), 1);
    chk("add_busy_idle", 32'(busy), 0);
    chk("add_hold_v1", 32'(alu_value1), 'h0003);

    // CMP r0,r0: same-register read, no write-back
    issue(mk_alu(2'b00, OP_CMP, 3'd0, 3'd0), a);
    @(negedge clk);
    @(negedge clk);
    chk("cmp_exec_v1", 32'(alu_value1), 'h1234);
    chk("cmp_exec_v2", 32'(alu_value2), 'h1234);
    chk("cmp_exec_op", 32'(alu_operator), 32'(OP_CMP));
    @(negedge clk);
    chk("cmp_wb_we", 32'(rf_we), 0);
    chk("cmp_wb_busy", 32'(busy), 1);
    @(negedge clk);
    chk("cmp_idle_ready", 32'(instr_ready), 1);

    // LSL r3 (rs=r2 must be ignored): 0x8001 << 1 = 0x0002
    issue(mk_alu(2'b01, OP_LSL, 3'd3, 3'd2), a);
    exp_q.push_back(ev_t'{K_WR, 3'd3, 16'h0002, a + 32'd2});
    @(negedge clk);
    @(negedge clk);
    chk("lsl_single", 32'(alu_single), 1);
    chk("lsl_v2_zero", 32'(alu_value2), 0);
    chk("lsl_v1", 32'(alu_value1), 'h8001);
    @(negedge clk);
    @(negedge clk);

    // RJMP -2: taken, offset sign-extended
    br_take = 1'b1;
    issue(mk_br(OP_RJMP, 10'h3FE), a);
    exp_q.push_back(ev_t'{K_PC, 3'd0, 16'hFFFE, a});
    @(negedge clk);
    chk("rjmp_busy", 32'(busy), 1);
    chk("rjmp_op", 32'(alu_operator), 32'(OP_RJMP));
    @(negedge clk);
    chk("rjmp_ready_next", 32'(instr_ready), 1);
    br_take = 1'b0;

    // BRNC not taken
    issue(mk_br(OP_BRNC, 10'h005), a);
    @(negedge clk);
    chk("brnc_nt_pc_load", 32'(pc_load), 0);
    chk("brnc_nt_busy", 32'(busy), 1);
    @(negedge clk);
    br_take = 1'b1;

    // BRNC taken, positive offset
    issue(mk_br(OP_BRNC, 10'h005), a);
    exp_q.push_back(ev_t'{K_PC, 3'd0, 16'h0005, a});
    @(negedge clk);
    @(negedge clk);

    // Reserved class dropped, ADD accepted on the very next edge
    issue(16'hC3A5, a);
    exp_q.push_back(ev_t'{K_ILL, 3'd0, 16'h0000, a});
    chk("ill_busy", 32'(busy), 0);
    chk("ill_ready", 32'(instr_ready), 1);
    issue(mk_alu(2'b00, OP_ADD, 3'd4, 3'd5), a2);
    exp_q.push_back(ev_t'{K_WR, 3'd4, 16'h0030, a2 + 32'd2});
    chk("ill_then_add_accept", a2, a + 32'd1);
    repeat (4) @(negedge clk);

    // Reset asserted during WB of ADD r6,r7: write discarded
    issue(mk_alu(2'b00, OP_ADD, 3'd6, 3'd7), a);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rstwb_we_gated", 32'(rf_we), 0);
    chk("rstwb_busy_before", 32'(busy), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstwb_ready", 32'(instr_ready), 1);
    chk("rstwb_busy", 32'(busy), 0);
    chk("rstwb_we", 32'(rf_we), 0);
    chk("rstwb_no_write", 32'(rf[6]), 'h0100);
    issue(mk_alu(2'b00, OP_ADD, 3'd6, 3'd7), a);
    exp_q.push_back(ev_t'{K_WR, 3'd6, 16'h0101, a + 32'd2});
    repeat (4) @(negedge clk);

    // Reset asserted during BRANCH: no pc_load
    br_take = 1'b1;
    issue(mk_br(OP_RJMP, 10'h010), a);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstbr_pc_load", 32'(pc_load), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstbr_busy", 32'(busy), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
